// File: rtl/abro_sequence_arbiter.sv
// Round-robin arbiter that time-shares one ABRO core between N_REQ requesters,
// running clear / A,B events / bounded wait for O per grant.
module abro_sequence_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15,
    parameter int TW      = 4,
    parameter int IDW     = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_order,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDW-1:0]   o_gnt_id,
    output logic             o_busy,
    output logic [N_REQ-1:0] o_done,
    output logic             o_err,
    output logic             o_core_reset,
    output logic             o_core_a,
    output logic             o_core_b,
    input  logic             i_core_o
);

    localparam int SW = IDW + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_EV1  = 3'd2,
        S_EV2  = 3'd3,
        S_WAIT = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t             r_state;
    logic [N_REQ-1:0]   r_gnt;
    logic [IDW-1:0]     r_win;
    logic               r_busy;
    logic [N_REQ-1:0]   r_done;
    logic               r_err;
    logic               r_core_reset;
    logic               r_core_a;
    logic               r_core_b;
    logic [IDW-1:0]     r_rr;
    logic               r_ord;
    logic [TW-1:0]      r_cnt;

    logic               w_found;
    logic [IDW-1:0]     w_winner;
    logic [IDW-1:0]     w_idx;

    // (base + step) mod N_REQ, with base < N_REQ and step < N_REQ
    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] base, input int step);
        logic [SW-1:0] sum;
        sum = {1'b0, base} + SW'(step);
        if (sum >= SW'(N_REQ)) begin
            sum = sum - SW'(N_REQ);
        end else begin
            sum = sum;
        end
        return sum[IDW-1:0];
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [IDW-1:0] idx);
        return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Round-robin search: first requesting index at or after the pointer
    always_comb begin
        w_found  = 1'b0;
        w_winner = {IDW{1'b0}};
        w_idx    = {IDW{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = wrap_inc(r_rr, k);
            if (!w_found && i_req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end else begin
                w_found  = w_found;
            end
        end
    end

    // Sequencer FSM with all outputs registered
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_gnt        <= {N_REQ{1'b0}};
            r_win        <= {IDW{1'b0}};
            r_busy       <= 1'b0;
            r_done       <= {N_REQ{1'b0}};
            r_err        <= 1'b0;
            r_core_reset <= 1'b1;
            r_core_a     <= 1'b0;
            r_core_b     <= 1'b0;
            r_rr         <= {IDW{1'b0}};
            r_ord        <= 1'b0;
            r_cnt        <= {TW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done   <= {N_REQ{1'b0}};
                    r_err    <= 1'b0;
                    r_core_a <= 1'b0;
                    r_core_b <= 1'b0;
                    if (w_found) begin
                        r_win        <= w_winner;
                        r_ord        <= i_order[w_winner];
                        r_gnt        <= onehot(w_winner);
                        r_busy       <= 1'b1;
                        r_core_reset <= 1'b1;
                        r_state      <= S_CLR;
                    end else begin
                        r_gnt        <= {N_REQ{1'b0}};
                        r_busy       <= 1'b0;
                        r_core_reset <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                S_CLR: begin
                    r_core_reset <= 1'b0;
                    r_core_a     <= ~r_ord;
                    r_core_b     <= r_ord;
                    r_state      <= S_EV1;
                end
                S_EV1: begin
                    r_core_a <= r_ord;
                    r_core_b <= ~r_ord;
                    r_state  <= S_EV2;
                end
                S_EV2: begin
                    r_core_a <= 1'b0;
                    r_core_b <= 1'b0;
                    r_cnt    <= {{(TW-1){1'b0}}, 1'b1};
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    // O has priority over an expiring counter in the same cycle
                    if (i_core_o) begin
                        r_done       <= onehot(r_win);
                        r_err        <= 1'b0;
                        r_core_reset <= 1'b1;
                        r_state      <= S_DONE;
                    end else if (r_cnt == TW'(TIMEOUT)) begin
                        r_done       <= onehot(r_win);
                        r_err        <= 1'b1;
                        r_core_reset <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                S_DONE: begin
                    r_gnt        <= {N_REQ{1'b0}};
                    r_busy       <= 1'b0;
                    r_done       <= {N_REQ{1'b0}};
                    r_err        <= 1'b0;
                    r_core_reset <= 1'b0;
                    r_rr         <= wrap_inc(r_win, 1);
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_gnt        <= {N_REQ{1'b0}};
                    r_busy       <= 1'b0;
                    r_done       <= {N_REQ{1'b0}};
                    r_err        <= 1'b0;
                    r_core_reset <= 1'b1;
                    r_core_a     <= 1'b0;
                    r_core_b     <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign o_gnt        = r_gnt;
    assign o_gnt_id     = r_win;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_core_reset = r_core_reset;
    assign o_core_a     = r_core_a;
    assign o_core_b     = r_core_b;

    abro_sequence_arbiter_chk #(.N_REQ(N_REQ)) u_chk (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_gnt    (r_gnt),
        .i_done   (r_done),
        .i_err    (r_err),
        .i_core_a (r_core_a),
        .i_core_b (r_core_b)
    );

endmodule

// Structural invariants of the arbiter outputs.
module abro_sequence_arbiter_chk #(
    parameter int N_REQ = 4
) (
    input logic             i_clk,
    input logic             i_rst_n,
    input logic [N_REQ-1:0] i_gnt,
    input logic [N_REQ-1:0] i_done,
    input logic             i_err,
    input logic             i_core_a,
    input logic             i_core_b
);

    a_gnt_onehot:  assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(i_gnt));
    a_done_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(i_done));
    a_ab_excl:     assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_core_a && i_core_b));
    a_done_gnt:    assert property (@(posedge i_clk) disable iff (!i_rst_n) (|i_done) |-> (i_gnt == i_done));
    a_err_done:    assert property (@(posedge i_clk) disable iff (!i_rst_n) i_err |-> (|i_done));

endmodule

// File: tb/tb_abro_sequence_arbiter.sv
// Randomized scoreboard bench: a timeline reference model predicts each sequence,
// a separate monitor compares every DUT output on the falling edge.
module tb_abro_sequence_arbiter;

    localparam int N   = 4;
    localparam int T   = 15;
    localparam int TW  = 4;
    localparam int IDW = 2;
    localparam int VW  = 2 * N + IDW + 5;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   order = '0;
    logic           core_o = 1'b0;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic [N-1:0]   done;
    logic           err;
    logic           core_reset;
    logic           core_a;
    logic           core_b;

    abro_sequence_arbiter #(.N_REQ(N), .TIMEOUT(T), .TW(TW), .IDW(IDW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req        (req),
        .i_order      (order),
        .o_gnt        (gnt),
        .o_gnt_id     (gnt_id),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_core_reset (core_reset),
        .o_core_a     (core_a),
        .o_core_b     (core_b),
        .i_core_o     (core_o)
    );

    // s = cycle of CLR, w = WAIT length, DONE lands at s+3+w
    typedef struct {
        int s;
        int win;
        bit ord;
        int w;
        bit err;
    } rec_t;

    rec_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rel_cyc = 0;
    int   rr = 0;
    int   free_cyc = 0;
    bit   granted = 1'b0;
    bit   active = 1'b0;
    int   ps = 0;
    int   plat = 0;
    int   pw = 0;
    bit   pgl = 1'b0;

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [VW-1:0] pack(input logic [N-1:0] g, input logic [IDW-1:0] id,
                                           input logic b, input logic [N-1:0] d, input logic e,
                                           input logic cr, input logic a, input logic bb);
        return {g, id, b, d, e, cr, a, bb};
    endfunction

    task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h (gnt,id,busy,done,err,crst,A,B)",
                     name, cyc, got, expv);
        end
    endtask

    // Monitor: compares the whole output vector each cycle against the front record
    initial begin
        int           prev_id;
        int           dc;
        rec_t         r;
        logic [VW-1:0] got;
        logic [VW-1:0] expv;
        prev_id = 0;
        forever begin
            @(negedge clk);
            got = pack(gnt, gnt_id, busy, done, err, core_reset, core_a, core_b);
            if (!rst_n) begin
                prev_id = 0;
                expv = pack('0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
                check("reset", got, expv);
            end else if (sbq.size() == 0 || cyc < sbq[0].s) begin
                expv = pack('0, IDW'(prev_id), 1'b0, '0, 1'b0, (cyc == rel_cyc), 1'b0, 1'b0);
                check("idle", got, expv);
            end else begin
                r  = sbq[0];
                dc = r.s + 3 + r.w;
                expv = pack(oh(r.win), IDW'(r.win), 1'b1,
                            (cyc == dc) ? oh(r.win) : '0,
                            (cyc == dc) && r.err,
                            (cyc == r.s) || (cyc == dc),
                            (cyc == r.s + 1 && !r.ord) || (cyc == r.s + 2 && r.ord),
                            (cyc == r.s + 1 && r.ord) || (cyc == r.s + 2 && !r.ord));
                if (cyc == dc) begin
                    check("done", got, expv);
                    void'(sbq.pop_front());
                    prev_id = r.win;
                end else begin
                    check("seq", got, expv);
                end
            end
        end
    end

    // One cycle of stimulus; rq applies when the model says the arbiter is idle
    task automatic drive_cycle(input logic [N-1:0] rq, input int ordv, input int latf, input bit hold);
        int   c;
        int   win;
        int   lat;
        rec_t r;
        @(posedge clk);
        #2;
        c = cyc;
        granted = 1'b0;
        order = (ordv < 0) ? N'($urandom_range(0, 15)) : N'(ordv);
        if (c >= free_cyc) begin
            req = rq;
            if (rq != '0) begin
                win = -1;
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && rq[(rr + k) % N]) win = (rr + k) % N;
                end
                lat   = (latf >= 0) ? latf : int'($urandom_range(1, T + 3));
                r.s   = c + 1;
                r.win = win;
                r.ord = order[win];
                r.w   = (lat <= T) ? lat : T;
                r.err = (lat > T);
                sbq.push_back(r);
                active   = 1'b1;
                ps       = r.s;
                plat     = lat;
                pw       = r.w;
                pgl      = (latf < 0) && ($urandom_range(0, 3) == 0);
                free_cyc = r.s + 4 + r.w;
                rr       = (win + 1) % N;
                granted  = 1'b1;
            end
        end else begin
            req = hold ? rq : N'($urandom_range(0, 15));
        end
        // Core model: O rises lat cycles after the second event; optional stray pulse in EV1
        core_o = active && ((pgl && c == ps + 1) || (c >= ps + 2 + plat && c <= ps + 3 + pw));
    endtask

    task automatic issue(input logic [N-1:0] rq, input int ordv, input int latf, input bit hold);
        int n;
        n = 0;
        granted = 1'b0;
        while (!granted && n < 100) begin
            drive_cycle(rq, ordv, latf, hold);
            n++;
        end
        total++;
        if (!granted) begin
            bad++;
            $display("FAIL issue_timeout cyc=%0d got=no_grant expected=grant", cyc);
        end
    endtask

    task automatic do_reset(input int hold_cycles);
        @(posedge clk);
        #2;
        rst_n  = 1'b0;
        sbq.delete();
        rr     = 0;
        active = 1'b0;
        core_o = 1'b0;
        req    = '0;
        repeat (hold_cycles) @(posedge clk);
        #2;
        rst_n    = 1'b1;
        rel_cyc  = cyc;
        free_cyc = cyc;
    endtask

    initial begin
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n    = 1'b1;
        rel_cyc  = cyc;
        free_cyc = cyc;

        issue(4'b0001, 0, 1, 1'b0);
        issue(4'b0100, 4, 1, 1'b0);
        for (int i = 0; i < 5; i++) issue(4'b1111, -1, 1, 1'b1);
        issue(4'b1000, -1, 100, 1'b0);
        issue(4'b0010, -1, 1, 1'b0);
        issue(4'b1111, -1, 1, 1'b0);
        issue(4'b0110, -1, T, 1'b0);
        issue(4'b0110, -1, T + 1, 1'b0);

        repeat (400) drive_cycle(N'($urandom_range(0, 15)), -1, -1, ($urandom_range(0, 1) == 1));

        issue(4'b0010, -1, 100, 1'b0);
        while (cyc < ps + 5) drive_cycle(4'b0000, -1, -1, 1'b0);
        do_reset(2);
        issue(4'b1111, -1, 1, 1'b0);
        issue(4'b0010, -1, 1, 1'b0);
        issue(4'b1111, -1, 1, 1'b0);

        repeat (25) drive_cycle(4'b0000, -1, -1, 1'b0);
        @(negedge clk);
        #1;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d_pending expected=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
